mem_access_unit: RTL and testbench

Load/store front-end that sits directly upstream of the big-endian, byte-addressed data memory and consumes its read data. It accepts one access per request (byte/half/word, signed/unsigned) and checks alignment and bounds. Sub-word stores are done as read-modify-write on the memory's 32-bit port, and sub-word loads are extracted and extended. Memory side: combinational read, write commits on clk negedge while mem_write=1.

---
 rtl/mem_access_unit.sv | 157 +++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store front-end for a big-endian, byte-addressed data memory.
// Checks alignment and bounds, does sub-word stores as read-modify-write, and extends sub-word loads.
module mem_access_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state_q;
    logic        write_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic        req_err;

    // Byte lane o sits at word[31-8*o -: 8]; half lane is picked by addr[1].
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            2'b00:   return {{24{b[7] & ~uns}}, b};
            2'b01:   return {{16{h[15] & ~uns}}, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic [15:0] wd);
        logic [31:0] m;
        m = word;
        if (size == 2'b00) begin
            case (off)
                2'd0:    m[31:24] = wd[7:0];
                2'd1:    m[23:16] = wd[7:0];
                2'd2:    m[15:8]  = wd[7:0];
                default: m[7:0]   = wd[7:0];
            endcase
        end else if (off[1]) begin
            m[15:0] = wd;
        end else begin
            m[31:16] = wd;
        end
        return m;
    endfunction

    // A 33-bit end address keeps addresses near 2^32 from wrapping past the bounds check.
    always_comb begin
        case (req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        end_addr = {1'b0, req_addr} + {30'b0, nbytes};
        req_err  = (req_size == 2'b11)
                || (req_size == 2'b01 && req_addr[0])
                || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                || (end_addr > 33'(MEM_BYTES));
    end

    assign req_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        uns_q   <= req_unsigned;
                        size_q  <= req_size;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (req_err) begin
                            state_q    <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_write && req_size == 2'b10) begin
                            state_q        <= WRITE;
                            mem_write      <= 1'b1;
                            mem_address    <= {req_addr[31:2], 2'b00};
                            mem_write_data <= req_wdata;
                        end else begin
                            state_q     <= READ;
                            mem_read    <= 1'b1;
                            mem_address <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                READ: begin
                    // mem_out is consumed at the closing edge, either merged for a store or extracted for a load.
                    mem_read <= 1'b0;
                    if (write_q) begin
                        state_q        <= WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= store_merge(mem_out, size_q, off_q, wdata_q);
                    end else begin
                        state_q    <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_extract(mem_out, size_q, off_q, uns_q);
                    end
                end
                WRITE: begin
                    mem_write  <= 1'b0;
                    state_q    <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: begin
                    resp_valid <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array memory on the memory port, a byte-level reference model,
// and a negedge compare process that checks strobes, addresses, readiness and responses.
module tb_mem_access_unit;

    localparam int MEM_BYTES = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_out;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    // Memory attached to the unit: combinational big-endian read, negedge commit.
    logic [7:0] dmem [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];
    int widx;
    assign widx = int'(mem_address[6:2]) * 4;
    assign mem_out = {dmem[widx], dmem[widx+1], dmem[widx+2], dmem[widx+3]};

    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            for (int i = 0; i < 4; i++) dmem[widx+i] <= mem_write_data[31-8*i -: 8];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] wdata;
        logic [31:0] addr;
        bit          err;
        int          lat;
        int          rd;
        int          wr;
        int          acc;
    } exp_t;

    exp_t expq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int wr_total = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: operate on bytes of ref_mem with plain arithmetic.
    task automatic model(input bit w, input bit [1:0] sz, input bit u, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e);
        int nb;
        longint ua;
        int base;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        ua = {32'b0, a};
        e.rdata = '0; e.wdata = '0; e.err = 0; e.lat = 0; e.rd = 0; e.wr = 0; e.acc = 0;
        e.addr = {a[31:2], 2'b00};
        e.err = (sz == 2'd3) || (ua % nb != 0) || (ua + nb > MEM_BYTES);
        if (e.err) begin
            e.lat = 1;
            return;
        end
        base = int'(ua);
        if (!w) begin
            v = '0;
            for (int i = 0; i < nb; i++) v = (v << 8) | {24'b0, ref_mem[base+i]};
            if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            e.rdata = v;
            e.lat = 2;
            e.rd = 1;
        end else begin
            for (int i = 0; i < nb; i++) ref_mem[base+i] = 8'(wd >> (8*(nb-1-i)));
            base = int'(e.addr);
            e.wdata = {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
            e.lat = (nb == 4) ? 2 : 3;
            e.rd = (nb == 4) ? 0 : 1;
            e.wr = 1;
        end
    endtask

    // Compare process: one sample per cycle, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mem_write === 1'b1) wr_total++;
        if (!rst_n) begin
            expq.delete();
            rd_cnt = 0;
            wr_cnt = 0;
            last_rdata = '0;
            last_err = 1'b0;
        end else begin
            check32("req_ready", {31'b0, req_ready}, {31'b0, expq.size() == 0});
            if (mem_read === 1'b1) rd_cnt++;
            if (mem_write === 1'b1) wr_cnt++;
            if (mem_read === 1'b1 || mem_write === 1'b1) begin
                if (expq.size() == 0) begin
                    check32("stray_mem_strobe", {30'b0, mem_read, mem_write}, 32'd0);
                end else begin
                    check32("mem_address", mem_address, expq[0].addr);
                    if (mem_write === 1'b1) check32("mem_write_data", mem_write_data, expq[0].wdata);
                end
            end
            if (resp_valid !== 1'b0) begin
                if (expq.size() == 0) begin
                    check32("unexpected_resp", {31'b0, resp_valid}, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check32("latency", 32'(cyc - e.acc), 32'(e.lat));
                    check32("resp_rdata", resp_rdata, e.rdata);
                    check32("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    check32("mem_read_cycles", 32'(rd_cnt), 32'(e.rd));
                    check32("mem_write_cycles", 32'(wr_cnt), 32'(e.wr));
                    last_rdata = e.rdata;
                    last_err = e.err;
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                check32("rdata_hold", resp_rdata, last_rdata);
                check32("err_hold", {31'b0, resp_err}, {31'b0, last_err});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (req_ready !== 1'b1) check32("ready_timeout", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic scramble();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_size = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
    endtask

    // chk pins the model against a hand value: rdata for loads, merged word for stores.
    task automatic do_req(input bit w, input bit [1:0] sz, input bit u, input logic [31:0] a,
                          input logic [31:0] wd, input bit chk, input logic [31:0] lit, input bit lerr);
        exp_t e;
        int n;
        wait_ready();
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_unsigned = u;
        req_addr = a;
        req_wdata = wd;
        model(w, sz, u, a, wd, e);
        if (chk) begin
            check32("model_literal", (w && !e.err) ? e.wdata : e.rdata, lit);
            check32("model_err_literal", {31'b0, e.err}, {31'b0, lerr});
        end
        @(posedge clk);
        e.acc = cyc;
        expq.push_back(e);
        #1;
        scramble();
        n = 0;
        while (expq.size() != 0 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (expq.size() != 0) begin
            check32("resp_timeout", 32'(expq.size()), 32'd0);
            expq.delete();
        end
    endtask

    initial begin
        exp_t dummy;
        int w0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            dmem[i] = 8'(i * 7 + 1);
            ref_mem[i] = 8'(i * 7 + 1);
        end
        begin
            logic [63:0] pre;
            pre = 64'h1122_3344_8566_7788;
            for (int i = 0; i < 8; i++) begin
                dmem[i] = pre[63-8*i -: 8];
                ref_mem[i] = pre[63-8*i -: 8];
            end
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check32("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check32("rst_resp_rdata", resp_rdata, 32'd0);
        check32("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check32("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        check32("rst_mem_address", mem_address, 32'd0);
        check32("rst_mem_write_data", mem_write_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Loads from the preloaded pattern
        do_req(0, 2'b10, 0, 32'd0, 32'd0, 1, 32'h1122_3344, 0);
        do_req(0, 2'b00, 0, 32'd4, 32'd0, 1, 32'hFFFF_FF85, 0);
        do_req(0, 2'b00, 1, 32'd4, 32'd0, 1, 32'h0000_0085, 0);
        do_req(0, 2'b01, 0, 32'd4, 32'd0, 1, 32'hFFFF_8566, 0);
        do_req(0, 2'b01, 1, 32'd6, 32'd0, 1, 32'h0000_7788, 0);
        do_req(0, 2'b00, 0, 32'd3, 32'd0, 1, 32'h0000_0044, 0);

        // Sub-word and word stores
        do_req(1, 2'b00, 0, 32'd5, 32'h0000_00AB, 1, 32'h85AB_7788, 0);
        do_req(0, 2'b10, 0, 32'd4, 32'd0, 1, 32'h85AB_7788, 0);
        do_req(1, 2'b10, 0, 32'd0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0);
        do_req(0, 2'b10, 0, 32'd0, 32'd0, 1, 32'hDEAD_BEEF, 0);
        do_req(1, 2'b01, 0, 32'd2, 32'h1234_CAFE, 1, 32'hDEAD_CAFE, 0);
        do_req(1, 2'b00, 0, 32'd3, 32'hFFFF_FF5A, 1, 32'hDEAD_CA5A, 0);
        do_req(0, 2'b10, 0, 32'd0, 32'd0, 1, 32'hDEAD_CA5A, 0);
        do_req(0, 2'b01, 0, 32'd0, 32'd0, 1, 32'hFFFF_DEAD, 0);

        // Error cases and bounds
        do_req(0, 2'b10, 0, 32'd2, 32'd0, 1, 32'd0, 1);
        do_req(1, 2'b01, 0, 32'd3, 32'h1111, 1, 32'd0, 1);
        do_req(0, 2'b11, 0, 32'd0, 32'd0, 1, 32'd0, 1);
        do_req(0, 2'b10, 0, 32'd128, 32'd0, 1, 32'd0, 1);
        do_req(0, 2'b10, 0, 32'hFFFF_FFFC, 32'd0, 1, 32'd0, 1);
        do_req(0, 2'b00, 1, 32'd128, 32'd0, 1, 32'd0, 1);
        do_req(0, 2'b01, 0, 32'd127, 32'd0, 1, 32'd0, 1);
        do_req(1, 2'b10, 0, 32'd124, 32'h0102_0304, 1, 32'h0102_0304, 0);
        do_req(0, 2'b10, 0, 32'd124, 32'd0, 1, 32'h0102_0304, 0);
        do_req(0, 2'b00, 0, 32'd127, 32'd0, 1, 32'h0000_0004, 0);
        do_req(0, 2'b01, 1, 32'd126, 32'd0, 1, 32'h0000_0304, 0);

        // Reset on the edge that would enter WRITE: no commit may happen
        wait_ready();
        w0 = wr_total;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b01;
        req_unsigned = 1'b0;
        req_addr = 32'd6;
        req_wdata = 32'h0000_1234;
        @(posedge clk);
        dummy.rdata = '0; dummy.wdata = '0; dummy.addr = 32'd4; dummy.err = 0;
        dummy.lat = 3; dummy.rd = 1; dummy.wr = 1; dummy.acc = cyc;
        expq.push_back(dummy);
        #1;
        scramble();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check32("abort_no_write", 32'(wr_total - w0), 32'd0);
        check32("abort_ready", {31'b0, req_ready}, 32'd1);
        do_req(0, 2'b01, 1, 32'd6, 32'd0, 1, 32'h0000_7788, 0);
        do_req(0, 2'b10, 0, 32'd4, 32'd0, 1, 32'h85AB_7788, 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
